// File: rtl/frame_checker.sv
// rtl/frame_checker.sv - byte-stream Ethernet/IPv4 header and length checker with frame counters
package frame_checker_pkg;

    typedef struct packed {
        logic        enable;
        logic [15:0] frame_size;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } port_config_t;

endpackage

module frame_checker
    import frame_checker_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int BYTE_CNT_WIDTH = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  port_config_t              port_config,
    input  logic [7:0]                axis_s_data,
    input  logic                      axis_s_valid,
    input  logic                      axis_s_last,
    output logic                      axis_s_ready,
    output logic                      running,
    output logic                      frame_done,
    output logic                      frame_ok,
    output logic [CNT_WIDTH-1:0]      good_frames,
    output logic [CNT_WIDTH-1:0]      bad_frames,
    output logic [BYTE_CNT_WIDTH-1:0] good_bytes
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        RECV,
        DISCARD
    } state_t;

    localparam logic [15:0] IDX_MAX = 16'hFFFF;

    state_t      state;
    logic [15:0] idx;
    logic        err_q;
    logic [95:0] mac_q;
    logic [63:0] ip_q;
    logic [15:0] size_q;

    logic         beat;
    logic         sof;
    logic [95:0]  mac_eff;
    logic [63:0]  ip_eff;
    logic [15:0]  size_eff;
    logic [111:0] hdr_sh;
    logic [63:0]  ip_sh;
    logic [2:0]   ip_sel;
    logic         check_hdr;
    logic         check_ip;
    logic         mismatch;
    logic         err_nxt;
    logic [16:0]  len;
    logic         frame_bad;
    logic         start_acc;
    logic         running_nxt;
    logic         commit;

    // Never back-pressures: ready simply follows reset release.
    assign axis_s_ready = rst;
    assign beat         = axis_s_valid && axis_s_ready;

    always_comb begin
        sof = (idx == 16'd0);

        // Byte 0 compares against the live config; the rest of the frame uses the snapshot.
        mac_eff  = sof ? {port_config.dst_mac, port_config.src_mac} : mac_q;
        ip_eff   = sof ? {port_config.src_ip, port_config.dst_ip} : ip_q;
        size_eff = sof ? port_config.frame_size : size_q;

        hdr_sh    = {mac_eff, 16'h0800} << {idx[3:0], 3'b000};
        ip_sel    = idx[2:0] - 3'd2;
        ip_sh     = ip_eff << {ip_sel, 3'b000};
        check_hdr = (idx < 16'd14);
        check_ip  = (idx >= 16'd26) && (idx <= 16'd33);

        mismatch = 1'b0;
        if (check_hdr && (axis_s_data != hdr_sh[111:104])) begin
            mismatch = 1'b1;
        end
        if (check_ip && (axis_s_data != ip_sh[63:56])) begin
            mismatch = 1'b1;
        end

        err_nxt   = (sof ? 1'b0 : err_q) | mismatch;
        len       = {1'b0, idx} + 17'd1;
        frame_bad = err_nxt || (len != {1'b0, size_eff}) || (len < 17'd34);

        // Stop wins over a simultaneous start.
        start_acc   = start && !stop && port_config.enable && !running;
        running_nxt = stop ? 1'b0 : (start_acc ? 1'b1 : running);

        commit = beat && axis_s_last &&
                 ((state == RECV) || ((state == WAIT_SOF) && running));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            err_q       <= 1'b0;
            mac_q       <= '0;
            ip_q        <= '0;
            size_q      <= '0;
            running     <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            good_frames <= '0;
            bad_frames  <= '0;
            good_bytes  <= '0;
        end else begin
            running    <= running_nxt;
            frame_done <= commit;
            frame_ok   <= commit && !frame_bad;

            if (beat) begin
                err_q <= err_nxt;
                if (sof) begin
                    mac_q  <= {port_config.dst_mac, port_config.src_mac};
                    ip_q   <= {port_config.src_ip, port_config.dst_ip};
                    size_q <= port_config.frame_size;
                end
                if (axis_s_last) begin
                    idx <= '0;
                end else if (idx != IDX_MAX) begin
                    idx <= idx + 16'd1;
                end
            end

            if (start_acc) begin
                good_frames <= '0;
                bad_frames  <= '0;
                good_bytes  <= '0;
            end else if (commit) begin
                if (frame_bad) begin
                    bad_frames <= bad_frames + CNT_WIDTH'(1);
                end else begin
                    good_frames <= good_frames + CNT_WIDTH'(1);
                    good_bytes  <= good_bytes + BYTE_CNT_WIDTH'(len);
                end
            end

            case (state)
                IDLE: begin
                    if (beat) begin
                        if (axis_s_last) begin
                            state <= running_nxt ? WAIT_SOF : IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (running_nxt) begin
                        state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (beat) begin
                        if (axis_s_last) begin
                            state <= running_nxt ? WAIT_SOF : IDLE;
                        end else begin
                            state <= running ? RECV : DISCARD;
                        end
                    end
                end
                RECV: begin
                    if (beat && axis_s_last) begin
                        state <= WAIT_SOF;
                    end
                end
                DISCARD: begin
                    if (beat && axis_s_last) begin
                        state <= running_nxt ? WAIT_SOF : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// tb/tb_frame_checker.sv - scoreboard bench for frame_checker with a frame-level reference model
module tb_frame_checker;
    import frame_checker_pkg::*;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        bit     ok;
        longint g;
        longint b;
        longint by;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    port_config_t port_config;
    logic [7:0]   axis_s_data;
    logic         axis_s_valid;
    logic         axis_s_last;
    logic         axis_s_ready;
    logic         running;
    logic         frame_done;
    logic         frame_ok;
    logic [31:0]  good_frames;
    logic [31:0]  bad_frames;
    logic [47:0]  good_bytes;

    int     total = 0;
    int     bad   = 0;
    exp_t   exp_q[$];
    bit     m_running;
    longint m_good;
    longint m_bad;
    longint m_bytes;

    frame_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .port_config  (port_config),
        .axis_s_data  (axis_s_data),
        .axis_s_valid (axis_s_valid),
        .axis_s_last  (axis_s_last),
        .axis_s_ready (axis_s_ready),
        .running      (running),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .good_frames  (good_frames),
        .bad_frames   (bad_frames),
        .good_bytes   (good_bytes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done: got 1 expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_ok", frame_ok, e.ok);
                check("done_good_frames", good_frames, e.g);
                check("done_bad_frames", bad_frames, e.b);
                check("done_good_bytes", good_bytes, e.by);
            end
        end
    end

    function automatic logic [7:0] field_byte(input logic [63:0] v, input int nbytes, input int i);
        return 8'(v >> (8 * (nbytes - 1 - i)));
    endfunction

    function automatic bit model_ok(input byte_q_t f, input port_config_t c);
        int n;
        n = f.size();
        if (n != int'(c.frame_size) || n < 34) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (f[i] != field_byte({16'h0, c.dst_mac}, 6, i)) return 1'b0;
            if (f[6 + i] != field_byte({16'h0, c.src_mac}, 6, i)) return 1'b0;
        end
        if (f[12] != 8'h08 || f[13] != 8'h00) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f[26 + i] != field_byte({32'h0, c.src_ip}, 4, i)) return 1'b0;
            if (f[30 + i] != field_byte({32'h0, c.dst_ip}, 4, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic byte_q_t make_frame(input int len, input port_config_t c);
        byte_q_t    f;
        logic [7:0] h [34];
        for (int i = 0; i < 34; i++) h[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            h[i]     = field_byte({16'h0, c.dst_mac}, 6, i);
            h[6 + i] = field_byte({16'h0, c.src_mac}, 6, i);
        end
        h[12] = 8'h08;
        h[13] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[26 + i] = field_byte({32'h0, c.src_ip}, 4, i);
            h[30 + i] = field_byte({32'h0, c.dst_ip}, 4, i);
        end
        for (int i = 0; i < len; i++) f.push_back(i < 34 ? h[i] : 8'($urandom));
        return f;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_running"}, running, m_running);
        check({tag, "_good_frames"}, good_frames, m_good);
        check({tag, "_bad_frames"}, bad_frames, m_bad);
        check({tag, "_good_bytes"}, good_bytes, m_bytes);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, axis_s_ready, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_ok"}, frame_ok, 0);
        check({tag, "_counters"}, good_frames | bad_frames | good_bytes, 0);
    endtask

    task automatic do_start(input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk);
        #1;
        if (with_stop) begin
            m_running = 1'b0;
        end else if (port_config.enable && !m_running) begin
            m_running = 1'b1;
            m_good    = 0;
            m_bad     = 0;
            m_bytes   = 0;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        m_running = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t f, input bit gaps, input int stop_at,
                              input int start_at, input int glitch_at, input int reset_at);
        port_config_t saved;
        bit           counted;
        bit           ok;
        bit           aborted;
        int           n;
        saved   = port_config;
        counted = m_running;
        ok      = model_ok(f, port_config);
        aborted = 1'b0;
        n       = f.size();
        for (int i = 0; i < n; i++) begin
            if (i == reset_at) begin
                axis_s_valid = 1'b0;
                axis_s_last  = 1'b0;
                rst          = 1'b0;
                #1;
                check_reset_outputs("reset_mid_frame");
                repeat (3) @(posedge clk);
                #1;
                check_reset_outputs("reset_held");
                rst       = 1'b1;
                m_running = 1'b0;
                m_good    = 0;
                m_bad     = 0;
                m_bytes   = 0;
                aborted   = 1'b1;
                break;
            end
            if (gaps && i > 0) begin
                axis_s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            axis_s_valid = 1'b1;
            axis_s_data  = f[i];
            axis_s_last  = (i == n - 1);
            if (i == stop_at) stop = 1'b1;
            if (i == start_at) start = 1'b1;
            if (i == glitch_at) begin
                port_config.src_ip     = ~port_config.src_ip;
                port_config.dst_mac    = ~port_config.dst_mac;
                port_config.frame_size = port_config.frame_size + 16'd1;
            end
            check("ready", axis_s_ready, 1);
            @(posedge clk);
            #1;
            if (i == stop_at) begin
                m_running = 1'b0;
            end else if (i == start_at && !m_running && port_config.enable) begin
                m_running = 1'b1;
                m_good    = 0;
                m_bad     = 0;
                m_bytes   = 0;
            end
            stop  = 1'b0;
            start = 1'b0;
        end
        axis_s_valid = 1'b0;
        axis_s_last  = 1'b0;
        port_config  = saved;
        if (!aborted) begin
            if (counted) begin
                exp_t e;
                if (ok) begin
                    m_good++;
                    m_bytes += n;
                end else begin
                    m_bad++;
                end
                e.ok = ok;
                e.g  = m_good;
                e.b  = m_bad;
                e.by = m_bytes;
                exp_q.push_back(e);
            end
            check("done_latency", frame_done, counted);
        end
    endtask

    function automatic port_config_t rand_config();
        port_config_t c;
        c.enable     = ($urandom_range(0, 4) != 0);
        c.frame_size = 16'($urandom_range(30, 80));
        c.src_mac    = {16'($urandom), 32'($urandom)};
        c.dst_mac    = {16'($urandom), 32'($urandom)};
        c.src_ip     = 32'($urandom);
        c.dst_ip     = 32'($urandom);
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t      f;
        port_config_t ref_cfg;

        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        axis_s_data  = 8'h00;
        axis_s_valid = 1'b0;
        axis_s_last  = 1'b0;
        ref_cfg.enable     = 1'b1;
        ref_cfg.frame_size = 16'd60;
        ref_cfg.dst_mac    = 48'h112233445566;
        ref_cfg.src_mac    = 48'haabbccddeeff;
        ref_cfg.src_ip     = 32'h12345678;
        ref_cfg.dst_ip     = 32'h87654321;
        port_config = ref_cfg;
        m_running = 1'b0;
        m_good    = 0;
        m_bad     = 0;
        m_bytes   = 0;

        #3 rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("ready_after_reset", axis_s_ready, 1);

        // Good reference frame.
        do_start(1'b0);
        check("running_after_start", running, 1);
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, -1, -1, -1);
        @(negedge clk);
        check("req021_good_frames", good_frames, 1);
        check("req021_good_bytes", good_bytes, 60);
        check("req021_bad_frames", bad_frames, 0);

        // Corrupted IP byte and short frame.
        do_stop();
        do_start(1'b0);
        f = make_frame(60, ref_cfg);
        f[31] = f[31] ^ 8'hff;
        send_frame(f, 1'b0, -1, -1, -1, -1);
        send_frame(make_frame(59, ref_cfg), 1'b0, -1, -1, -1, -1);
        @(negedge clk);
        check("req022_bad_frames", bad_frames, 2);
        check("req022_good_frames", good_frames, 0);

        // Valid toggling mid-frame.
        do_stop();
        do_start(1'b0);
        send_frame(make_frame(60, ref_cfg), 1'b1, -1, -1, -1, -1);
        @(negedge clk);
        check("req023_good_frames", good_frames, 1);
        check("req023_good_bytes", good_bytes, 60);

        // Stop at byte 20, then one more frame left uncounted.
        send_frame(make_frame(60, ref_cfg), 1'b0, 20, -1, -1, -1);
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, -1, -1, -1);
        @(negedge clk);
        check("req024_good_frames", good_frames, 2);
        check("req024_running", running, 0);

        // Start/stop collision.
        do_start(1'b1);
        check_state("req025");
        check("req025_good_frames", good_frames, 2);

        // Reset at byte 40, then a fresh frame.
        do_start(1'b0);
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, -1, -1, 40);
        do_start(1'b0);
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, -1, -1, -1);
        @(negedge clk);
        check("req026_good_frames", good_frames, 1);
        check_state("req026");

        // Start while a frame is flowing in IDLE: that frame stays uncounted.
        do_stop();
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, 10, -1, -1);
        send_frame(make_frame(60, ref_cfg), 1'b0, -1, -1, 30, -1);
        check_state("start_mid_frame");

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            int r;
            int len;
            int stop_at;
            int start_at;
            int glitch_at;
            r = $urandom_range(0, 9);
            if (r == 0) do_stop();
            else if (r == 1) do_start(1'b0);
            else if (r == 2) port_config = rand_config();
            else if (r == 3) do_start(1'b1);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : int'(port_config.frame_size);
            f = make_frame(len, port_config);
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, len - 1);
                f[p] = f[p] ^ 8'($urandom_range(1, 255));
            end
            stop_at   = (m_running && $urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
            start_at  = (!m_running && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            glitch_at = (len > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
            send_frame(f, 1'($urandom_range(0, 1)), stop_at, start_at, glitch_at, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check_state("random");
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
